formatter: RTL and testbench

MCDF packet formatter: downstream sequencer for the channel arbiter. It pulses an ID request to the arbiter and reads back the granted channel. It then collects one packet of pkglen words through the arbiter's val/ack path into a local 32-word buffer, and replays that packet on the MCDF output port under a req/grant handshake with start/end framing. Only one packet is in flight at a time.

---
 rtl/formatter.sv | 159 +++++++++++++++
 tb/tb_formatter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/formatter.sv
// MCDF packet formatter: fetches a channel ID from the arbiter, buffers one
// packet of up to 32 words, then replays it on the output port with framing.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing in flight; request arbitration next cycle
// REQ       | f2a_id_req_o pulse
// ID_WAIT   | arbiter ID valid; latch chid/len or retry on 2'b11
// COLLECT   | ack held high, words written to the local buffer
// PKT_REQ   | packet buffered, fmt_req_o held until grant
// SEND      | one buffered word per cycle with start/end framing
module formatter (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        a2f_val_i,
  input  logic [1:0]  a2f_id_i,
  input  logic [31:0] a2f_data_i,
  input  logic [2:0]  a2f_pkglen_sel_i,
  output logic        f2a_id_req_o,
  output logic        f2a_ack_o,
  input  logic        fmt_grant_i,
  output logic        fmt_req_o,
  output logic [1:0]  fmt_chid_o,
  output logic [5:0]  fmt_length_o,
  output logic [31:0] fmt_data_o,
  output logic        fmt_start_o,
  output logic        fmt_end_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ID_WAIT,
    S_COLLECT,
    S_PKT_REQ,
    S_SEND
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  chid_q, chid_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  wr_cnt_q, wr_cnt_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic        id_req_q, id_req_d;
  logic        ack_q, ack_d;
  logic        req_q, req_d;
  logic [31:0] data_q, data_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        wr_en;
  logic [31:0] mem_q [32];

  function automatic logic [5:0] decode_len(input logic [2:0] sel);
    case (sel)
      3'd0:    decode_len = 6'd4;
      3'd1:    decode_len = 6'd8;
      3'd2:    decode_len = 6'd16;
      default: decode_len = 6'd32;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    chid_d   = chid_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    data_d   = '0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = S_ID_WAIT;
      S_ID_WAIT: begin
        if (a2f_id_i == 2'b11) begin
          state_d = S_IDLE;
        end else begin
          chid_d   = a2f_id_i;
          len_d    = decode_len(a2f_pkglen_sel_i);
          wr_cnt_d = '0;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (a2f_val_i && ack_q) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == len_q - 6'd1) state_d = S_PKT_REQ;
        end
      end
      S_PKT_REQ: begin
        if (fmt_grant_i) begin
          rd_cnt_d = '0;
          data_d   = mem_q[0];
          start_d  = 1'b1;
          end_d    = (len_q == 6'd1);
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        // Data for the next cycle is prefetched so every output stays registered.
        if (rd_cnt_q == len_q - 6'd1) begin
          state_d = S_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 6'd1;
          data_d   = mem_q[rd_cnt_d[4:0]];
          end_d    = (rd_cnt_d == len_q - 6'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    id_req_d = (state_d == S_REQ);
    ack_d    = (state_d == S_COLLECT);
    req_d    = (state_d == S_PKT_REQ);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      chid_q   <= '0;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      id_req_q <= 1'b0;
      ack_q    <= 1'b0;
      req_q    <= 1'b0;
      data_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chid_q   <= chid_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      id_req_q <= id_req_d;
      ack_q    <= ack_d;
      req_q    <= req_d;
      data_q   <= data_d;
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_cnt_q[4:0]] <= a2f_data_i;
  end

  assign f2a_id_req_o = id_req_q;
  assign f2a_ack_o    = ack_q;
  assign fmt_req_o    = req_q;
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_data_o   = data_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;

endmodule

// File: tb/tb_formatter.sv
// Directed bench for formatter: a table of packet scenarios driven through a
// behavioural arbiter stand-in, plus hand-written reset and back-to-back cases.
module tb_formatter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        a2f_val_i;
  logic [1:0]  a2f_id_i;
  logic [31:0] a2f_data_i;
  logic [2:0]  a2f_pkglen_sel_i;
  logic        f2a_id_req_o;
  logic        f2a_ack_o;
  logic        fmt_grant_i;
  logic        fmt_req_o;
  logic [1:0]  fmt_chid_o;
  logic [5:0]  fmt_length_o;
  logic [31:0] fmt_data_o;
  logic        fmt_start_o;
  logic        fmt_end_o;

  int n_vec = 0;
  int n_err = 0;

  formatter dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .a2f_val_i        (a2f_val_i),
    .a2f_id_i         (a2f_id_i),
    .a2f_data_i       (a2f_data_i),
    .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
    .f2a_id_req_o     (f2a_id_req_o),
    .f2a_ack_o        (f2a_ack_o),
    .fmt_grant_i      (fmt_grant_i),
    .fmt_req_o        (fmt_req_o),
    .fmt_chid_o       (fmt_chid_o),
    .fmt_length_o     (fmt_length_o),
    .fmt_data_o       (fmt_data_o),
    .fmt_start_o      (fmt_start_o),
    .fmt_end_o        (fmt_end_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  chid;
    logic [2:0]  sel;
    bit          toggle;
    int          gdelay;
    logic [31:0] base;
    logic [5:0]  exp_len;
    bit          grant_in_collect;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
                 fmt_data_o, fmt_start_o, fmt_end_o}, 64'd0);
  endtask

  task automatic wait_idreq();
    for (int i = 0; i < 8 && f2a_id_req_o !== 1'b1; i++) tick();
    check("id_req_pulse", f2a_id_req_o, 1);
  endtask

  // Runs one packet; in_collect means the DUT is already in its first ack cycle.
  task automatic run_packet(input vec_t v, input bit in_collect);
    int cyc;
    int words;
    bit ok;
    bit frm_ok;
    if (!in_collect) begin
      wait_idreq();
      a2f_id_i         = v.chid;
      a2f_pkglen_sel_i = v.sel;
      a2f_val_i        = 1'b0;
      tick();
      check("idwait_idreq", f2a_id_req_o, 0);
      check("idwait_ack", f2a_ack_o, 0);
      tick();
    end
    // Arbiter outputs move after ID_WAIT; the latched values must govern.
    a2f_id_i         = 2'b11;
    a2f_pkglen_sel_i = v.sel ^ 3'b001;
    ok    = 1'b1;
    cyc   = 0;
    words = 0;
    while (words < int'(v.exp_len) && cyc < 200) begin
      if (f2a_ack_o !== 1'b1) ok = 1'b0;
      a2f_val_i   = v.toggle ? (cyc % 2 == 1) : 1'b1;
      a2f_data_i  = a2f_val_i ? v.base + words : 32'hDEAD_0000 + cyc;
      fmt_grant_i = v.grant_in_collect && (cyc == 1);
      if (a2f_val_i) words++;
      tick();
      fmt_grant_i = 1'b0;
      cyc++;
    end
    a2f_val_i = 1'b0;
    check("ack_during_collect", ok, 1);
    check("ack_after_collect", f2a_ack_o, 0);
    ok = 1'b1;
    for (int i = 0; i <= v.gdelay; i++) begin
      if (fmt_req_o !== 1'b1 || fmt_chid_o !== v.chid || fmt_length_o !== v.exp_len ||
          fmt_start_o !== 1'b0 || fmt_data_o !== 32'd0) ok = 1'b0;
      if (i < v.gdelay) tick();
    end
    check("pkt_req_stable", ok, 1);
    fmt_grant_i = 1'b1;
    tick();
    fmt_grant_i = 1'b0;
    check("req_drop", fmt_req_o, 0);
    frm_ok = 1'b1;
    for (int i = 0; i < int'(v.exp_len); i++) begin
      check("send_data", fmt_data_o, v.base + i);
      if (fmt_start_o !== (i == 0) || fmt_end_o !== (i == int'(v.exp_len) - 1) ||
          fmt_chid_o !== v.chid || fmt_length_o !== v.exp_len || fmt_req_o !== 1'b0)
        frm_ok = 1'b0;
      tick();
    end
    check("send_framing", frm_ok, 1);
    check("after_send_data", fmt_data_o, 0);
    check("after_send_end", fmt_end_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{chid: 2'd1, sel: 3'd0, toggle: 1'b0, gdelay: 0,  base: 32'h0000_00A0, exp_len: 6'd4,  grant_in_collect: 1'b0};
    vecs[1] = '{chid: 2'd2, sel: 3'd7, toggle: 1'b1, gdelay: 2,  base: 32'h0000_1000, exp_len: 6'd32, grant_in_collect: 1'b0};
    vecs[2] = '{chid: 2'd0, sel: 3'd2, toggle: 1'b0, gdelay: 20, base: 32'h0000_2000, exp_len: 6'd16, grant_in_collect: 1'b1};
    vecs[3] = '{chid: 2'd2, sel: 3'd1, toggle: 1'b1, gdelay: 1,  base: 32'h0000_3000, exp_len: 6'd8,  grant_in_collect: 1'b0};
    vecs[4] = '{chid: 2'd1, sel: 3'd3, toggle: 1'b0, gdelay: 0,  base: 32'h0000_4000, exp_len: 6'd32, grant_in_collect: 1'b0};
    vecs[5] = '{chid: 2'd0, sel: 3'd4, toggle: 1'b0, gdelay: 3,  base: 32'hCAFE_0000, exp_len: 6'd32, grant_in_collect: 1'b1};

    rstn_i           = 1'b0;
    a2f_val_i        = 1'b0;
    a2f_id_i         = 2'b11;
    a2f_data_i       = '0;
    a2f_pkglen_sel_i = '0;
    fmt_grant_i      = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");

    // Released away from an edge: edge 1 enters REQ, the arbiter sees the pulse at edge 2.
    rstn_i = 1'b1;
    check("idle_after_release", f2a_id_req_o, 0);
    tick();
    check("first_id_req", f2a_id_req_o, 1);
    for (int i = 1; i < 12; i++) begin
      tick();
      check("noreq_id_req", f2a_id_req_o, (i % 3 == 0));
      check("noreq_ack", f2a_ack_o, 0);
      check("noreq_fmt_req", fmt_req_o, 0);
    end

    for (int k = 0; k < 6; k++) run_packet(vecs[k], 1'b0);

    // Reset after 2 of 8 words collected.
    wait_idreq();
    a2f_id_i         = 2'd2;
    a2f_pkglen_sel_i = 3'd1;
    tick();
    tick();
    check("mid_ack", f2a_ack_o, 1);
    for (int k = 0; k < 2; k++) begin
      a2f_val_i  = 1'b1;
      a2f_data_i = 32'h0000_BAD0 + k;
      tick();
    end
    a2f_val_i = 1'b0;
    rstn_i    = 1'b0;
    #1;
    check_all_zero("reset_mid_collect");
    tick();
    tick();
    rstn_i = 1'b1;
    check("idle_after_rerelease", f2a_id_req_o, 0);
    tick();
    check("id_req_after_reset", f2a_id_req_o, 1);
    v = '{chid: 2'd2, sel: 3'd1, toggle: 1'b0, gdelay: 0, base: 32'h0000_5000, exp_len: 6'd8, grant_in_collect: 1'b0};
    run_packet(v, 1'b0);

    // Back-to-back: 3 dead cycles between fmt_end_o and the next ack.
    v = '{chid: 2'd1, sel: 3'd0, toggle: 1'b0, gdelay: 0, base: 32'h0000_6000, exp_len: 6'd4, grant_in_collect: 1'b0};
    run_packet(v, 1'b0);
    a2f_id_i         = 2'd2;
    a2f_pkglen_sel_i = 3'd0;
    check("b2b_ack_idle", f2a_ack_o, 0);
    tick();
    check("b2b_ack_req", f2a_ack_o, 0);
    check("b2b_id_req", f2a_id_req_o, 1);
    tick();
    check("b2b_ack_idwait", f2a_ack_o, 0);
    tick();
    check("b2b_ack_rise", f2a_ack_o, 1);
    v = '{chid: 2'd2, sel: 3'd0, toggle: 1'b0, gdelay: 1, base: 32'h0000_7000, exp_len: 6'd4, grant_in_collect: 1'b0};
    run_packet(v, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
